stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes and a registered output stage. It generalises the team's fixed 4:1 combinational mux. The channel is chosen either by an external select (fixed mode) or by a round-robin arbiter. Its intended use is as the merge point where several producer streams share one downstream consumer.

## Interface
Parameters:
- `N`, 4, number of input channels (≥2; need not be a power of two)
- `W`, 8, data width per channel
- `SELW`, `$clog2(N)`, width of select and channel-index fields (derived; do not override)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mode`  in  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR)
- `sel`  in  SELW  channel index used in fixed mode
- `in_data`  in  N*W  channel i occupies bits [i*W +: W]
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready, at most one bit high (one-hot or zero)
- `out_data`  out  W  registered output data
- `out_chan`  out  SELW  index of the channel that produced `out_data`
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  consumer accepts the beat

## Operation
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_chan`=0, round-robin pointer `ptr`=0.
  - `in_ready` is all-zero while `rst`=1.
- **Load enable:** `load = !out_valid | out_ready`. The output register is empty or is being drained this cycle.
- **Grant, fixed mode:**
  - Valid only when `sel < N` and `in_valid[sel]`; the granted index is `sel`.
  - `sel ≥ N` never grants.
- **Grant, round-robin mode:**
  - The granted index is the first i with `in_valid[i]` set, scanning `ptr, ptr+1, …` modulo N.
  - There is no grant when `in_valid` is all-zero.
- **Ready:** `in_ready[g]` = `load & grant_valid & !rst`. All other bits are 0.
- **Input transfer:** occurs when `in_valid[g] & in_ready[g]`. On the next edge:
  - `out_data` ← `in_data[g]`, `out_chan` ← g, `out_valid` ← 1.
  - `ptr` ← (g == N-1) ? 0 : g+1.
- `ptr` advances on every input transfer in either mode. It holds otherwise, and a mode switch does not change it.
- **Drain without refill:** when `out_valid & out_ready` and there is no input transfer, `out_valid` ← 0. `out_data` and `out_chan` hold their last values.
- **Stall:** when `out_valid & !out_ready`, all outputs hold and `in_ready` is 0.
- **Simultaneous drain and load:** the register is overwritten with the new beat and `out_valid` stays 1. This gives full throughput of one beat per cycle.
- `mode` and `sel` are sampled combinationally each cycle. A change takes effect on the same cycle's grant and never corrupts a beat already in the register.
- **Reset mid-operation:** any held beat is discarded (`out_valid`→0 at the edge) and `ptr`→0. No input transfer is accepted in the reset cycle.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`.
- Throughput is 1 beat/cycle while `out_ready` stays high.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, `sel`, `ptr` and `out_valid`. This is a combinational path from `out_ready` to `in_ready`.
- `out_*` are purely registered. There is no combinational path from inputs to `out_*`.
- **Round-robin fairness:** with all N channels continuously valid and `out_ready`=1, each channel is granted exactly once in every N consecutive transfers.

## Structure
- **Shared package (`stream_mux_pkg`):**
  - `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1.
  - A function computing SELW from N.
- **One sub-module, `rr_arbiter`:**
  - Parameter N.
  - Inputs are `req[N-1:0]` and `ptr[SELW-1:0]`; outputs are `grant_idx[SELW-1:0]` and `grant_valid`.
  - Purely combinational rotating-priority search.
  - The top level adds the fixed-mode path, the output register, `ptr` and the handshake.

## Test plan
- **Reset:** hold `rst` 3 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0 throughout. The first transfer after release grants channel 0 (RR).
- **Fixed mode:** N=4, W=8, `mode`=0, `sel`=2, `in_data` ch2=8'hA5, all valid, `out_ready`=1 → `in_ready`=4'b0100. Next cycle `out_data`=8'hA5, `out_chan`=2. Switching `sel`=3 gives ch3 data on the following beat.
- **Round-robin:** all 4 channels valid, `out_ready`=1 for 8 cycles → `out_chan` sequence 0,1,2,3,0,1,2,3. With only ch1 and ch3 valid → 1,3,1,3.
- **Backpressure:** `out_ready`=0 while `out_valid`=1 for 5 cycles → `out_data`/`out_chan` stable, `in_ready`=0. Raising `out_ready` yields back-to-back beats with no bubble.
- **Boundary:**
  - N=3, `sel`=3 in fixed mode → no grant, `in_ready`=0, `out_valid` drains to 0.
  - RR with `ptr`=2 and only ch0 valid → grant 0, `ptr` wraps to 1.
- **Reset mid-stream:** assert `rst` for 1 cycle while `out_valid`=1 and `ptr`=2 → beat dropped, `ptr`=0, no transfer in the reset cycle.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index for an n-channel mux (at least one bit).
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_valid
);

  // Doubling the request vector and shifting by ptr puts req[(ptr+k) mod N]
  // at bit k, so the search becomes a plain lowest-set-bit scan.
  logic [2*N-1:0] req_rot;
  assign req_rot = {req, req} >> ptr;

  // Lowest set bit of the rotated vector, mapped back to a channel index.
  always_comb begin
    int c;
    grant_idx   = '0;
    grant_valid = 1'b0;
    c           = 0;
    for (int k = 0; k < N; k++) begin
      if (!grant_valid && req_rot[k]) begin
        c = int'(ptr) + k;
        if (c >= N) c = c - N;
        grant_valid = 1'b1;
        grant_idx   = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed or round-robin channel choice
// and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  // Channel-indexed views padded to a power of two, so any sel value
  // (including sel >= N) indexes safely and reads as "not valid".
  localparam int NP = 1 << SELW;

  logic [NP-1:0]         vld_pad;
  logic [NP-1:0][W-1:0]  data_arr;
  logic [NP-1:0]         rdy_pad;

  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] chan_q, chan_d;
  logic            valid_q, valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [SELW-1:0] rr_idx;
  logic            rr_vld;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            load;
  logic            xfer;

  assign vld_pad = NP'(in_valid);

  // Unpack the flat input bus into per-channel words; pad slots are zero.
  always_comb begin
    data_arr = '0;
    for (int i = 0; i < N; i++) data_arr[i] = in_data[i*W +: W];
  end

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req        (in_valid),
    .ptr        (ptr_q),
    .grant_idx  (rr_idx),
    .grant_valid(rr_vld)
  );

  // Grant selection and handshake: fixed path uses sel directly, RR path
  // uses the arbiter. Ready is only raised when the output can take a beat.
  always_comb begin
    gnt_idx = sel;
    gnt_vld = vld_pad[sel];
    if (mode == MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
    end
    load    = !valid_q || out_ready;
    xfer    = load && gnt_vld && !rst;
    rdy_pad = '0;
    if (xfer) rdy_pad[gnt_idx] = 1'b1;
    in_ready = rdy_pad[N-1:0];
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = data_arr[gnt_idx];
      chan_d  = gnt_idx;
      valid_d = 1'b1;
      ptr_d   = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that drops any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule
